sync_fifo_flags: RTL and testbench

- Parametrised single-clock FIFO: configurable width and depth, plus fill level, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Generic buffering primitive between producer/consumer blocks in the lab designs (serialisers, sequence detectors, RAM front-ends).

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 28 ++
 rtl/sync_fifo_flags.sv | 169 ++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: pointer/level sizing and read-mode constants.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Width of pointers and the level counter: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: WIDTH x DEPTH register array, one synchronous write port,
// one asynchronous read port. The array is intentionally not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the write word on the rising edge when the top accepts a write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with level, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, synchronous flush and standard or FWFT read mode.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = MODE_STD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   level,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] ONE_P = PW'(1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc_s, rd_acc_s;
  logic             mem_we_s;
  logic [WIDTH-1:0] mem_rdata_s;

  // Accept decisions use the flags registered at the start of the cycle; flush blocks both.
  always_comb begin
    wr_acc_s = wr_en && !full_q && !clr;
    rd_acc_s = rd_en && !empty_q && !clr;
    mem_we_s = wr_acc_s;
  end

  // Next-state for pointers, level, sticky errors and the level-decoded flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      level_d  = {PW{1'b0}};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + ONE_P;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + ONE_P;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_d = level_q + ONE_P;
        2'b01:   level_d = level_q - ONE_P;
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (wr_en & full_q);
      // A read paired with a write into an empty FIFO is a benign stall, not an error.
      unf_d = unf_q | (rd_en & empty_q & ~wr_en);
    end
    full_d   = (level_d == PW'(DEPTH));
    empty_d  = (level_d == {PW{1'b0}});
    afull_d  = (level_d >= PW'(AFULL_TH));
    aempty_d = (level_d <= PW'(AEMPTY_TH));
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {PW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata_s)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      // Head word is presented directly whenever the FIFO holds data.
      assign rd_data  = empty_q ? {WIDTH{1'b0}} : mem_rdata_s;
      assign rd_valid = ~empty_q;
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      // Registered read port: capture the head word on an accepted read; hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= {WIDTH{1'b0}};
          rd_valid_q <= 1'b0;
        end else if (clr) begin
          rd_data_q  <= rd_data_q;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc_s;
          if (rd_acc_s) begin
            rd_data_q <= mem_rdata_s;
          end else begin
            rd_data_q <= rd_data_q;
          end
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO share one stimulus
// stream and are compared every cycle against a queue-based model.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, f_full, s_empty, f_empty;
  logic       s_afull, f_afull, s_aempty, f_aempty;
  logic [3:0] s_level, f_level;
  logic       s_ovf, f_ovf, s_unf, f_unf;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_svalid = 1'b0;
  logic [7:0] m_sdata = 8'h00;
  int         m_n;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_afull), .almost_empty(s_aempty), .level(s_level),
    .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf));

  // 10 ns clock.
  always #5 clk = ~clk;

  // Model: occupancy is the queue length; each edge applies the accept rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_svalid = 1'b0;
      m_sdata = 8'h00;
    end else if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_svalid = 1'b0;
    end else begin
      m_n = mq.size();
      if (wr_en && m_n == 8) m_ovf = 1'b1;
      if (rd_en && m_n == 0 && !wr_en) m_unf = 1'b1;
      m_svalid = rd_en && (m_n != 0);
      if (rd_en && m_n != 0) m_sdata = mq.pop_front();
      if (wr_en && m_n != 8) mq.push_back(wr_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] head;
    n = mq.size();
    head = (n == 0) ? 8'h00 : mq[0];
    chk("s_level",  32'(s_level),  32'(n));
    chk("f_level",  32'(f_level),  32'(n));
    chk("s_full",   32'(s_full),   32'(n == 8));
    chk("f_full",   32'(f_full),   32'(n == 8));
    chk("s_empty",  32'(s_empty),  32'(n == 0));
    chk("f_empty",  32'(f_empty),  32'(n == 0));
    chk("s_afull",  32'(s_afull),  32'(n >= 6));
    chk("f_afull",  32'(f_afull),  32'(n >= 6));
    chk("s_aempty", 32'(s_aempty), 32'(n <= 2));
    chk("f_aempty", 32'(f_aempty), 32'(n <= 2));
    chk("s_ovf",    32'(s_ovf),    32'(m_ovf));
    chk("f_ovf",    32'(f_ovf),    32'(m_ovf));
    chk("s_unf",    32'(s_unf),    32'(m_unf));
    chk("f_unf",    32'(f_unf),    32'(m_unf));
    chk("s_rd_valid", 32'(s_rd_valid), 32'(m_svalid));
    chk("s_rd_data",  32'(s_rd_data),  32'(m_sdata));
    chk("f_rd_valid", 32'(f_rd_valid), 32'(n != 0));
    chk("f_rd_data",  32'(f_rd_data),  32'(head));
  endtask

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) check_all();

  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic c);
    wr_en = we; wr_data = wd; rd_en = re; clr = c;
    @(posedge clk);
    #2;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_level", 32'(s_level), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_aempty", 32'(s_aempty), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_valid", 32'(s_rd_valid), 32'd0);
    rst_n = 1'b1;

    // Fill to full and watch the threshold flags.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 2) chk("aempty_after2", 32'(s_aempty), 32'd1);
      if (i == 3) chk("aempty_after3", 32'(s_aempty), 32'd0);
      if (i == 5) chk("afull_after5", 32'(s_afull), 32'd0);
      if (i == 6) chk("afull_after6", 32'(s_afull), 32'd1);
    end
    chk("full_after8", 32'(s_full), 32'd1);
    chk("level_after8", 32'(s_level), 32'd8);

    // Write while full: rejected, sticky overflow.
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("level_hold8", 32'(f_level), 32'd8);

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(s_rd_data), 32'(i));
      chk("drain_valid", 32'(s_rd_valid), 32'd1);
    end
    chk("drain_empty", 32'(s_empty), 32'd1);

    // Read while empty: sticky underflow, no valid data.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(s_unf), 32'd1);
    chk("unf_novalid", 32'(s_rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(s_ovf), 32'd0);
    chk("clr_unf", 32'(s_unf), 32'd0);

    // Wrap-around: advance pointers by 5, then push/pop 8 across the wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_data", 32'(s_rd_data), 32'(8'h10 + i));
    end
    chk("wrap_level", 32'(s_level), 32'd0);

    // Simultaneous push/pop at level 3.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      chk("simul_level", 32'(s_level), 32'd3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("simul_lastdata", 32'(s_rd_data), 32'h49);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("both_empty_level", 32'(s_level), 32'd1);
    chk("both_empty_unf", 32'(s_unf), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT presentation and pop.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_data", 32'(f_rd_data), 32'hA5);
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("std_novalid", 32'(s_rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop_data", 32'(f_rd_data), 32'd0);

    // Asynchronous reset between edges at level 5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(s_level), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(s_level), 32'd0);
    chk("arst_empty", 32'(f_empty), 32'd1);
    chk("arst_valid", 32'(f_rd_valid), 32'd0);
    check_all();
    #2 rst_n = 1'b1;

    // Flush with a same-cycle write at level 4: write dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("clr_level", 32'(s_level), 32'd0);
    chk("clr_empty", 32'(s_empty), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_dropped", 32'(f_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
